// File: rtl/ntt_seq_driver_if.sv
// Handshake bundle between the NTT sequence driver, its vector store and the NTT core.
// The driver takes the master modport; the store/NTT/test side takes the slave modport.
interface ntt_seq_driver_if #(
  parameter int DATA_W     = 64,
  parameter int RING_DEPTH = 12
);
  logic                    go;
  logic                    skip_w;
  logic                    src_req;
  logic [2:0]              src_sel;
  logic [RING_DEPTH:0]     src_idx;
  logic [DATA_W-1:0]       src_data;
  logic                    ntt_load_w;
  logic                    ntt_load_data;
  logic                    ntt_start;
  logic [DATA_W-1:0]       ntt_din;
  logic                    ntt_done;
  logic [DATA_W-1:0]       ntt_dout;
  logic                    busy;
  logic                    pass;
  logic                    fail;
  logic                    timeout;
  logic [RING_DEPTH:0]     err_cnt;
  logic [RING_DEPTH-1:0]   first_err;

  modport master (
    input  go, skip_w, src_data, ntt_done, ntt_dout,
    output src_req, src_sel, src_idx, ntt_load_w, ntt_load_data, ntt_start, ntt_din,
           busy, pass, fail, timeout, err_cnt, first_err
  );

  modport slave (
    output go, skip_w, src_data, ntt_done, ntt_dout,
    input  src_req, src_sel, src_idx, ntt_load_w, ntt_load_data, ntt_start, ntt_din,
           busy, pass, fail, timeout, err_cnt, first_err
  );
endinterface

// File: rtl/ntt_seq_driver.sv
// Streams twiddles and data into an NTT core, then checks its output against golden words.
// Define NTT_SEQ_WATCHDOG_EN to bound the wait for ntt_done by WAIT_MAX cycles.
module ntt_seq_driver #(
  parameter int DATA_W     = 64,
  parameter int RING_DEPTH = 12,
  parameter int PE_DEPTH   = 3,
  parameter int WAIT_MAX   = 1 << 20
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  ntt_seq_driver_if.master   io_bus
);
  localparam int N     = 1 << RING_DEPTH;
  localparam int TW    = ((1 << (RING_DEPTH - PE_DEPTH)) - 1 + PE_DEPTH) << PE_DEPTH;
  localparam int WLEN  = 2 * TW + 2;
  localparam int CMAX  = (WLEN > N) ? WLEN : N;
  localparam int CNT_W = $clog2(CMAX + 1);

  localparam logic [CNT_W-1:0] C_TW       = CNT_W'(TW);
  localparam logic [CNT_W-1:0] C_TW2      = CNT_W'(2 * TW);
  localparam logic [CNT_W-1:0] C_WLEN_M1  = CNT_W'(WLEN - 1);
  localparam logic [CNT_W-1:0] C_WLEN_M3  = CNT_W'(WLEN - 3);
  localparam logic [CNT_W-1:0] C_N_M1     = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] C_N_M3     = CNT_W'(N - 3);
  localparam logic [CNT_W-1:0] C_GAP_M1   = CNT_W'(4);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TWO      = CNT_W'(2);
  localparam logic [RING_DEPTH:0] C_N     = (RING_DEPTH + 1)'(N);
  localparam logic [RING_DEPTH:0] C_E1    = (RING_DEPTH + 1)'(1);

  typedef enum logic [3:0] {
    IDLE, LDW, WSTREAM, GAP1, LDD, DSTREAM, GAP2, START, WAIT, CAPT, REPORT
  } state_t;

  typedef enum logic [2:0] {
    SEL_W = 3'd0, SEL_WINV = 3'd1, SEL_Q = 3'd2, SEL_NINV = 3'd3, SEL_DIN = 3'd4, SEL_EXP = 3'd5
  } sel_t;

  state_t                r_state, w_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_fidx, w_idx;
  sel_t                  w_fsel, w_sel;
  logic                  w_fetch, w_fw, w_ld_w, w_ld_d, w_start;
  logic                  w_go_acc, w_miss, w_wd_exp;
  logic                  r_req_d;
  logic [DATA_W-1:0]     r_din;
  logic                  r_busy, r_pass, r_fail, r_timeout;
  logic [RING_DEPTH:0]   r_err_cnt;
  logic [RING_DEPTH-1:0] r_first_err;

  // The fetch for word 0 must leave in the go cycle itself, so acceptance is combinational.
  assign w_go_acc = (r_state == IDLE) && io_bus.go && i_rst_n;
  assign w_miss   = (io_bus.ntt_dout != io_bus.src_data);

`ifdef NTT_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WAIT_MAX + 1);
  logic [WD_W-1:0] r_wdog;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               r_wdog <= '0;
    else if (r_state == WAIT)   r_wdog <= r_wdog + WD_W'(1);
    else                        r_wdog <= '0;
  end

  assign w_wd_exp = (r_state == WAIT) && (r_wdog == WD_W'(WAIT_MAX - 1));
`else
  assign w_wd_exp = 1'b0;
`endif

  // Fetches run two words ahead of ntt_din: one cycle store latency, one cycle output register.
  always_comb begin
    w_nxt   = r_state;
    w_fetch = 1'b0;
    w_fw    = 1'b0;
    w_fidx  = '0;
    w_fsel  = SEL_DIN;
    w_ld_w  = 1'b0;
    w_ld_d  = 1'b0;
    w_start = 1'b0;
    case (r_state)
      IDLE: if (w_go_acc) begin
        w_fetch = 1'b1;
        if (io_bus.skip_w) w_nxt = LDD;
        else begin
          w_nxt = LDW;
          w_fw  = 1'b1;
        end
      end
      LDW: begin
        w_ld_w  = 1'b1;
        w_fetch = 1'b1;
        w_fw    = 1'b1;
        w_fidx  = C_ONE;
        w_nxt   = WSTREAM;
      end
      WSTREAM: begin
        if (r_cnt <= C_WLEN_M3) begin
          w_fetch = 1'b1;
          w_fw    = 1'b1;
          w_fidx  = r_cnt + C_TWO;
        end
        if (r_cnt == C_WLEN_M1) w_nxt = GAP1;
      end
      GAP1: if (r_cnt == C_GAP_M1) begin
        w_fetch = 1'b1;
        w_nxt   = LDD;
      end
      LDD: begin
        w_ld_d  = 1'b1;
        w_fetch = 1'b1;
        w_fidx  = C_ONE;
        w_nxt   = DSTREAM;
      end
      DSTREAM: begin
        if (r_cnt <= C_N_M3) begin
          w_fetch = 1'b1;
          w_fidx  = r_cnt + C_TWO;
        end
        if (r_cnt == C_N_M1) w_nxt = GAP2;
      end
      GAP2: if (r_cnt == C_GAP_M1) w_nxt = START;
      START: begin
        w_start = 1'b1;
        w_nxt   = WAIT;
      end
      WAIT: begin
        if (io_bus.ntt_done) begin
          w_fetch = 1'b1;
          w_fsel  = SEL_EXP;
          w_nxt   = CAPT;
        end else if (w_wd_exp) begin
          w_nxt = IDLE;
        end
      end
      CAPT: begin
        w_fsel = SEL_EXP;
        if (r_cnt < C_N_M1) begin
          w_fetch = 1'b1;
          w_fidx  = r_cnt + C_ONE;
        end else begin
          w_nxt = REPORT;
        end
      end
      REPORT: w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Twiddle-phase stream index maps onto W, WINV, Q, NINV in that order.
  always_comb begin
    w_sel = w_fsel;
    w_idx = w_fidx;
    if (w_fw) begin
      if (w_fidx < C_TW) begin
        w_sel = SEL_W;
      end else if (w_fidx < C_TW2) begin
        w_sel = SEL_WINV;
        w_idx = w_fidx - C_TW;
      end else if (w_fidx == C_TW2) begin
        w_sel = SEL_Q;
        w_idx = '0;
      end else begin
        w_sel = SEL_NINV;
        w_idx = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req_d <= 1'b0;
      r_din   <= '0;
    end else begin
      r_state <= w_nxt;
      r_req_d <= w_fetch;
      r_din   <= r_req_d ? io_bus.src_data : '0;
      if (w_nxt != r_state)
        r_cnt <= '0;
      else if (r_state inside {WSTREAM, GAP1, DSTREAM, GAP2, CAPT})
        r_cnt <= r_cnt + C_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else if (w_go_acc) begin
      r_busy      <= 1'b1;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else if (r_state == CAPT && w_miss) begin
      if (r_err_cnt != C_N) r_err_cnt <= r_err_cnt + C_E1;
      if (r_err_cnt == '0)  r_first_err <= r_cnt[RING_DEPTH-1:0];
    end else if (r_state == REPORT) begin
      r_pass <= (r_err_cnt == '0);
      r_fail <= (r_err_cnt != '0);
      r_busy <= 1'b0;
    end else if (w_wd_exp && !io_bus.ntt_done) begin
      r_timeout <= 1'b1;
      r_fail    <= 1'b1;
      r_pass    <= 1'b0;
      r_busy    <= 1'b0;
    end
  end

  assign io_bus.src_req       = w_fetch;
  assign io_bus.src_sel       = w_fetch ? 3'(w_sel) : 3'd0;
  assign io_bus.src_idx       = w_fetch ? (RING_DEPTH + 1)'(w_idx) : '0;
  assign io_bus.ntt_load_w    = w_ld_w;
  assign io_bus.ntt_load_data = w_ld_d;
  assign io_bus.ntt_start     = w_start;
  assign io_bus.ntt_din       = r_din;
  assign io_bus.busy          = r_busy;
  assign io_bus.pass          = r_pass;
  assign io_bus.fail          = r_fail;
  assign io_bus.timeout       = r_timeout;
  assign io_bus.err_cnt       = r_err_cnt;
  assign io_bus.first_err     = r_first_err;
endmodule

// File: tb/tb_ntt_seq_driver.sv
// Randomized bench for ntt_seq_driver: table store model, echoing NTT model, cycle-trace reference.
module tb_ntt_seq_driver;
  localparam int DW   = 64;
  localparam int RD   = 4;
  localparam int PD   = 1;
  localparam int N    = 1 << RD;
  localparam int TW   = ((1 << (RD - PD)) - 1 + PD) << PD;
  localparam int WMAX = 100;
  localparam int RW   = DW + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ntt_seq_driver_if #(.DATA_W(DW), .RING_DEPTH(RD)) bus ();

  ntt_seq_driver #(.DATA_W(DW), .RING_DEPTH(RD), .PE_DEPTH(PD), .WAIT_MAX(WMAX)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  logic [DW-1:0] tw_w [TW];
  logic [DW-1:0] tw_wi[TW];
  logic [DW-1:0] t_q, t_ninv;
  logic [DW-1:0] t_din[N];
  logic [DW-1:0] t_exp[N];

  logic          m_done = 1'b0, inj_done = 1'b0;
  logic [DW-1:0] m_dout = '0;
  logic [N-1:0]  g_badm = '0;
  bit            g_hold = 1'b0;
  bit            cap_en = 1'b0;
  int            cyc = 0;
  int            start_cyc = -1;
  int            n_vec = 0;
  int            n_err = 0;
  logic [RW-1:0] obs_q[$];
  logic [RW-1:0] exp_q[$];
  bit            msk_q[$];

  assign bus.ntt_done = m_done | inj_done;
  assign bus.ntt_dout = m_dout;

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rd_tbl(input logic [2:0] sel, input logic [RD:0] idx);
    int i;
    i = int'(idx);
    case (sel)
      3'd0:    rd_tbl = (i < TW) ? tw_w[i]  : '1;
      3'd1:    rd_tbl = (i < TW) ? tw_wi[i] : '1;
      3'd2:    rd_tbl = t_q;
      3'd3:    rd_tbl = t_ninv;
      3'd4:    rd_tbl = (i < N) ? t_din[i] : '1;
      3'd5:    rd_tbl = (i < N) ? t_exp[i] : '1;
      default: rd_tbl = '1;
    endcase
  endfunction

  // Vector store: one-cycle read latency, junk when not strobed.
  always @(posedge clk)
    bus.src_data <= bus.src_req ? rd_tbl(bus.src_sel, bus.src_idx) : {$urandom, $urandom};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cap_en) obs_q.push_back({bus.ntt_load_w, bus.ntt_load_data, bus.ntt_start, bus.ntt_din});
    if (bus.ntt_start === 1'b1) start_cyc = cyc;
    if (bus.ntt_load_w || bus.ntt_load_data || bus.ntt_start)
      chk("pulse_excl", $countones({bus.ntt_load_w, bus.ntt_load_data, bus.ntt_start}), 1);
  end

  // NTT model: after start, raise done once and stream golden words, corrupting masked indices.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.ntt_start === 1'b1 && !g_hold) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 m_done = 1'b1;
        @(posedge clk);
        #1 m_done = 1'b0;
        for (int k = 0; k < N; k++) begin
          m_dout = t_exp[k] ^ (g_badm[k] ? (64'h1 << $urandom_range(0, 63)) : 64'h0);
          @(posedge clk);
          #1;
        end
        m_dout = {$urandom, $urandom};
      end
    end
  end

  task automatic fill();
    foreach (tw_w[i])  tw_w[i]  = {$urandom, $urandom};
    foreach (tw_wi[i]) tw_wi[i] = {$urandom, $urandom};
    foreach (t_din[i]) t_din[i] = {$urandom, $urandom};
    foreach (t_exp[i]) t_exp[i] = {$urandom, $urandom};
    t_q    = {$urandom, $urandom};
    t_ninv = {$urandom, $urandom};
  endtask

  task automatic push_exp(input logic [2:0] pulses, input logic [DW-1:0] din, input bit cmp_din);
    exp_q.push_back({pulses, din});
    msk_q.push_back(cmp_din);
  endtask

  task automatic build_trace(input bit skip);
    exp_q.delete();
    msk_q.delete();
    if (!skip) begin
      push_exp(3'b100, '0, 1'b0);
      for (int i = 0; i < TW; i++) push_exp(3'b000, tw_w[i], 1'b1);
      for (int i = 0; i < TW; i++) push_exp(3'b000, tw_wi[i], 1'b1);
      push_exp(3'b000, t_q, 1'b1);
      push_exp(3'b000, t_ninv, 1'b1);
      for (int i = 0; i < 5; i++) push_exp(3'b000, '0, 1'b1);
    end
    push_exp(3'b010, '0, 1'b0);
    for (int i = 0; i < N; i++) push_exp(3'b000, t_din[i], 1'b1);
    for (int i = 0; i < 5; i++) push_exp(3'b000, '0, 1'b1);
    push_exp(3'b001, '0, 1'b0);
  endtask

  task automatic accept_go(input bit skip);
    @(posedge clk);
    #1 bus.go = 1'b1;
    bus.skip_w = skip;
    @(posedge clk);
    #1 bus.go = 1'b0;
    bus.skip_w = 1'($urandom);
  endtask

  task automatic run(input bit skip, input logic [N-1:0] badm, input bit inj);
    int c;
    int first;
    logic [RW-1:0] g, e;
    fill();
    g_badm = badm;
    g_hold = 1'b0;
    build_trace(skip);
    obs_q.delete();
    accept_go(skip);
    cap_en = 1'b1;
    chk("busy_on", bus.busy, 1);
    chk("status_clr", {bus.pass, bus.fail, bus.timeout, bus.err_cnt, bus.first_err}, 0);
    c = 1;
    while (bus.busy && c < 3000) begin
      @(posedge clk);
      #1 c++;
      bus.go   = inj && (c == 5);
      inj_done = inj && (c == 45);
    end
    bus.go = 1'b0;
    inj_done = 1'b0;
    cap_en = 1'b0;
    chk("run_bound", c < 3000, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= obs_q.size()) begin
        chk("trace_len", obs_q.size(), exp_q.size());
        break;
      end
      g = obs_q[i];
      e = exp_q[i];
      if (!msk_q[i]) begin
        g[DW-1:0] = '0;
        e[DW-1:0] = '0;
      end
      chk($sformatf("trace[%0d]", i), g, e);
    end
    for (int i = exp_q.size(); i < obs_q.size(); i++)
      chk("post_start_pulse", obs_q[i][RW-1:DW], 0);
    first = 0;
    for (int k = N - 1; k >= 0; k--) if (badm[k]) first = k;
    chk("pass", bus.pass, (badm == '0));
    chk("fail", bus.fail, (badm != '0));
    chk("err_cnt", bus.err_cnt, $countones(badm));
    chk("first_err", bus.first_err, first);
    chk("timeout", bus.timeout, 0);
    repeat (3) @(posedge clk);
    #1 chk("hold", {bus.busy, bus.pass, bus.fail}, {1'b0, badm == '0, badm != '0});
  endtask

  task automatic reset_mid();
    fill();
    g_badm = '0;
    accept_go(1'b0);
    repeat (48) @(posedge clk);
    #1 chk("din_word7", bus.ntt_din, t_din[7]);
    rst_n = 1'b0;
    #1;
    chk("rst_status", {bus.busy, bus.pass, bus.fail, bus.timeout, bus.err_cnt, bus.first_err}, 0);
    chk("rst_src", {bus.src_req, bus.src_sel, bus.src_idx}, 0);
    chk("rst_ntt", {bus.ntt_load_w, bus.ntt_load_data, bus.ntt_start, bus.ntt_din}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic hang_run();
    int c;
    fill();
    g_hold = 1'b1;
    start_cyc = -1;
    accept_go(1'b1);
    c = 1;
    while (bus.busy && c < 400) begin
      @(posedge clk);
      #1 c++;
    end
    chk("start_seen", start_cyc >= 0, 1);
`ifdef NTT_SEQ_WATCHDOG_EN
    chk("wd_latency", cyc - start_cyc, WMAX + 1);
    chk("wd_status", {bus.busy, bus.pass, bus.fail, bus.timeout}, 4'b0011);
`else
    chk("nowd_busy", bus.busy, 1);
    chk("nowd_timeout", bus.timeout, 0);
    rst_n = 1'b0;
    #1 chk("nowd_rst", bus.busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
`endif
    g_hold = 1'b0;
  endtask

  initial begin
    logic [N-1:0] m;
    bus.go = 1'b0;
    bus.skip_w = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_status", {bus.busy, bus.pass, bus.fail, bus.timeout, bus.err_cnt, bus.first_err}, 0);
    chk("reset_src", {bus.src_req, bus.src_sel, bus.src_idx}, 0);
    chk("reset_ntt", {bus.ntt_load_w, bus.ntt_load_data, bus.ntt_start, bus.ntt_din}, 0);
    rst_n = 1'b1;

    run(1'b0, '0, 1'b0);
    m = '0;
    m[3] = 1'b1;
    m[9] = 1'b1;
    run(1'b0, m, 1'b0);
    run(1'b1, '0, 1'b0);
    run(1'b1, '1, 1'b0);
    run(1'b0, '0, 1'b1);
    repeat (4) begin
      m = ($urandom_range(0, 1) == 1) ? N'($urandom) : '0;
      run(1'($urandom), m, 1'b0);
    end
    reset_mid();
    run(1'b0, '0, 1'b0);
    hang_run();
    m = '0;
    m[N-1] = 1'b1;
    run(1'b1, m, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ntt_seq_driver.md
NTT_SEQ_DRIVER -- requirements
Module: ntt_seq_driver

Interface
REQ-001 Parameter DATA_W, default 64: coefficient/twiddle word width.
REQ-002 Parameter RING_DEPTH, default 12: log2 ring size N; N = 2^RING_DEPTH.
REQ-003 Parameter PE_DEPTH, default 3: log2 PE count; TW = (2^(RING_DEPTH-PE_DEPTH) - 1 + PE_DEPTH) << PE_DEPTH.
REQ-004 Parameter WAIT_MAX, default 2^20: watchdog limit in cycles.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 go  in  1  one-cycle run request, honoured only in IDLE.
REQ-008 skip_w  in  1  sampled with go; 1 = omit twiddle load phase.
REQ-009 src_req  out  1  word read strobe to vector store.
REQ-010 src_sel  out  3  table: 0 W, 1 WINV, 2 Q, 3 NINV, 4 DIN, 5 EXP.
REQ-011 src_idx  out  RING_DEPTH+1  word index within table.
REQ-012 src_data  in  DATA_W  word, valid exactly one cycle after src_req.
REQ-013 ntt_load_w, ntt_load_data, ntt_start  out  1 each  NTT command pulses.
REQ-014 ntt_din  out  DATA_W  registered word to NTT.
REQ-015 ntt_done  in  1;  ntt_dout  in  DATA_W  NTT completion and result stream.
REQ-016 busy, pass, fail, timeout  out  1 each  run status.
REQ-017 err_cnt  out  RING_DEPTH+1  mismatch count;  first_err  out  RING_DEPTH  index of first mismatch.

Function
REQ-018 FSM states: IDLE, LDW, WSTREAM, GAP1, LDD, DSTREAM, GAP2, START, WAIT, CAPT, REPORT.
REQ-019 IDLE + go: clear pass/fail/timeout/err_cnt/first_err, assert busy, go to LDW (skip_w=0) or LDD (skip_w=1).
REQ-020 LDW: ntt_load_w high exactly one cycle; WSTREAM drives ntt_din for 2*TW+2 consecutive cycles: W[0..TW-1], WINV[0..TW-1], Q, NINV.
REQ-021 LDD: ntt_load_data high one cycle; DSTREAM drives DIN[0..N-1] for N consecutive cycles.
REQ-022 Word k of a stream SHALL appear on ntt_din in the (k+1)-th cycle after its load pulse cycle; src_req is issued early enough (prefetch) that no stream has a gap.
REQ-023 GAP1 and GAP2 last exactly 5 cycles each, ntt_din held at 0.
REQ-024 START: ntt_start high one cycle, then WAIT.
REQ-025 WAIT: on ntt_done=1 go to CAPT; ntt_dout word k is sampled at cycle (done cycle + 1 + k), k = 0..N-1.
REQ-026 CAPT compares each sampled word with EXP[k] (fetched via src_req aligned to the sample); mismatch increments err_cnt; first mismatch latches first_err.
REQ-027 REPORT (one cycle): pass = (err_cnt==0), fail = !pass, busy drops, return IDLE; status holds until next accepted go.
REQ-028 go outside IDLE is ignored; ntt_done outside WAIT is ignored.
REQ-029 Index counters wrap only via explicit reset at phase entry; err_cnt saturates at N.
REQ-030 Command pulses are mutually exclusive; at most one high per cycle.

Reset
REQ-031 reset low asynchronously forces IDLE; all outputs 0 (busy, pass, fail, timeout, err_cnt, first_err, src_req, src_sel, src_idx, ntt_* outputs).
REQ-032 reset mid-run abandons the run with no pulse or status emitted; the next go starts from LDW/LDD.

Configuration
REQ-033 Macro NTT_SEQ_WATCHDOG_EN defined: WAIT counts cycles; reaching WAIT_MAX without ntt_done sets timeout=1, fail=1, pass=0, goes to IDLE with busy low.
REQ-034 Macro undefined: no counter, timeout tied 0, WAIT persists until ntt_done or reset.

Verification
REQ-035 N=16, PE_DEPTH=1, model NTT echoing golden EXP, go with skip_w=0 -> 2*TW+2 words in order, 5-cycle gaps, pass=1, err_cnt=0.
REQ-036 Same, model corrupts dout words 3 and 9 -> fail=1, err_cnt=2, first_err=3.
REQ-037 go with skip_w=1 -> no ntt_load_w pulse; ntt_load_data one cycle after go acceptance; pass=1.
REQ-038 ntt_done withheld, WAIT_MAX=100, watchdog enabled -> timeout=1, fail=1 at 100 cycles in WAIT; disabled -> busy stays 1.
REQ-039 reset low during DSTREAM word 7 -> all outputs 0 immediately; next go completes with pass=1.
REQ-040 go pulsed during WSTREAM and ntt_done pulsed during DSTREAM -> both ignored, stream order and final result unchanged.
